// File: rtl/clk_div_pkg.sv
// Shared defaults and the per-channel action encoding for the multi-channel clock divider.
// The action order mirrors the channel priority: sync, disable, terminal count, count.
package clk_div_pkg;

  localparam int CNT_W_DEF       = 32;
  localparam int DEFAULT_DIV_DEF = 50;

  typedef enum logic [1:0] {
    ACT_SYNC  = 2'd0,
    ACT_HALT  = 2'd1,
    ACT_WRAP  = 2'd2,
    ACT_COUNT = 2'd3
  } ch_act_e;

  function automatic ch_act_e pick_act(input logic sync, input logic en, input logic at_term);
    if (sync)
      return ACT_SYNC;
    else if (!en)
      return ACT_HALT;
    else if (at_term)
      return ACT_WRAP;
    else
      return ACT_COUNT;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: half-period counter, active divisor and a single-entry pending divisor.
// Every output is a flop, so nothing on the input side reaches the outputs combinationally.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             div_we,
  input  logic [CNT_W-1:0] div_in,
  output logic             clk_out,
  output logic             tick,
  output logic             div_pend
);

  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] div_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term;
  ch_act_e          act;

  // A divisor of 0 behaves as 1, so the terminal count never underflows.
  always_comb begin
    term = (div_act == '0) ? '0 : div_act - CNT_W'(1);
    act  = pick_act(sync, en, cnt == term);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      case (act)
        ACT_SYNC, ACT_HALT: begin
          cnt     <= '0;
          clk_out <= 1'b0;
          tick    <= 1'b0;
        end
        ACT_WRAP: begin
          cnt     <= '0;
          clk_out <= ~clk_out;
          tick    <= 1'b1;
        end
        default: begin
          cnt  <= cnt + CNT_W'(1);
          tick <= 1'b0;
        end
      endcase
    end
  end

  // div_pend doubles as the pending-valid flag. A write always lands in the pending slot and
  // blocks promotion in its own cycle, so it is applied only by a later wrap, sync or disable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_act  <= CNT_W'(DEFAULT_DIV);
      div_nxt  <= '0;
      div_pend <= 1'b0;
    end else if (div_we) begin
      div_nxt  <= div_in;
      div_pend <= 1'b1;
    end else if (div_pend && act != ACT_COUNT) begin
      div_act  <= div_nxt;
      div_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// NCH independent 50%-duty clock dividers sharing one clock, with a common phase-align pulse.
// This level only slices the divisor bus and fans sync out to every channel.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       en,
  input  logic                 sync,
  input  logic [NCH-1:0]       div_we,
  input  logic [NCH*CNT_W-1:0] div_in,
  output logic [NCH-1:0]       clk_out,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       div_pend
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .sync     (sync),
      .div_we   (div_we[i]),
      .div_in   (div_in[i*CNT_W +: CNT_W]),
      .clk_out  (clk_out[i]),
      .tick     (tick[i]),
      .div_pend (div_pend[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: expected tick cycles and levels are queued when stimulus
// is driven and popped whenever a channel ticks inside its observation window.
module tb_clk_div_multi;

  localparam int NCH         = 2;
  localparam int CNT_W       = 16;
  localparam int DEFAULT_DIV = 50;

  typedef struct {
    int   cyc;
    logic lvl;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic                 sync;
  logic [NCH-1:0]       en;
  logic [NCH-1:0]       div_we;
  logic [NCH*CNT_W-1:0] div_in;
  logic [NCH-1:0]       clk_out;
  logic [NCH-1:0]       tick;
  logic [NCH-1:0]       div_pend;

  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   mon_lo [NCH];
  int   mon_hi [NCH];
  exp_t q0[$];
  exp_t q1[$];

  clk_div_multi #(
    .NCH         (NCH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync     (sync),
    .div_we   (div_we),
    .div_in   (div_in),
    .clk_out  (clk_out),
    .tick     (tick),
    .div_pend (div_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc counts rising edges; after edge N it reads N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    if (c > cyc) step(c - cyc);
  endtask

  task automatic push(input int ch, input int c, input logic l);
    exp_t e;
    e.cyc = c;
    e.lvl = l;
    if (ch == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Queue a run of n toggles every d cycles starting at first, levels alternating from 1.
  task automatic push_run(input int ch, input int first, input int d, input int n);
    for (int k = 0; k < n; k++) push(ch, first + k * d, (k % 2) == 0);
  endtask

  task automatic score(input int ch);
    exp_t e;
    int   n;
    n = (ch == 0) ? q0.size() : q1.size();
    if (n == 0) begin
      check($sformatf("ch%0d_unexpected_tick_at_%0d", ch, cyc), 1, 0);
    end else begin
      if (ch == 0) e = q0.pop_front();
      else e = q1.pop_front();
      check($sformatf("ch%0d_tick_cycle", ch), cyc, e.cyc);
      check($sformatf("ch%0d_level_at_%0d", ch, e.cyc), int'(clk_out[ch]), int'(e.lvl));
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++)
      if (tick[i] && cyc >= mon_lo[i] && cyc <= mon_hi[i]) score(i);
  end

  task automatic close_windows();
    for (int i = 0; i < NCH; i++) begin
      mon_lo[i] = 1;
      mon_hi[i] = 0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    close_windows();
    rst    = 1'b0;
    sync   = 1'b0;
    en     = '0;
    div_we = '0;
    div_in = '0;

    // Reset state
    step(3);
    check("rst_clk_out", int'(clk_out), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_pend", int'(div_pend), 0);
    rst = 1'b1;
    step(2);

    // Divisors 3 and 5: periods 6 and 10, one tick per 3 and per 5 cycles
    div_in = {16'd5, 16'd3};
    div_we = 2'b11;
    step(1);
    div_we = '0;
    check("t1_pend_set", int'(div_pend), 3);
    step(1);
    check("t1_pend_applied", int'(div_pend), 0);
    en = 2'b11;
    k  = cyc;
    push_run(0, k + 3, 3, 8);
    push_run(1, k + 5, 5, 5);
    mon_lo[0] = k + 1; mon_hi[0] = k + 24;
    mon_lo[1] = k + 1; mon_hi[1] = k + 25;
    wait_until(k + 27);
    check("t1_q0_drained", q0.size(), 0);
    check("t1_q1_drained", q1.size(), 0);
    en = '0;
    close_windows();
    step(1);
    check("t1_off_clk_out", int'(clk_out), 0);
    check("t1_off_tick", int'(tick), 0);

    // D=4 running, write 2 while cnt=1: current half-period keeps 4, then 2
    div_in[15:0] = 16'd4;
    div_we = 2'b01;
    step(1);
    div_we = '0;
    step(1);
    en = 2'b01;
    k  = cyc;
    push(0, k + 4, 1'b1); push(0, k + 6, 1'b0);
    push(0, k + 8, 1'b1); push(0, k + 10, 1'b0);
    mon_lo[0] = k + 1; mon_hi[0] = k + 10;
    step(1);
    div_in[15:0] = 16'd2;
    div_we = 2'b01;
    step(1);
    div_we = '0;
    check("t2_pend_k2", int'(div_pend[0]), 1);
    step(1);
    check("t2_pend_k3", int'(div_pend[0]), 1);
    step(1);
    check("t2_pend_cleared_at_wrap", int'(div_pend[0]), 0);
    wait_until(k + 12);
    check("t2_q0_drained", q0.size(), 0);
    en = '0;
    close_windows();
    step(2);

    // Write coincident with a wrap waits one more wrap; back-to-back 7 then 9 keeps 9
    div_in[15:0] = 16'd4;
    div_we = 2'b01;
    step(1);
    div_we = '0;
    step(1);
    en = 2'b01;
    k  = cyc;
    push(0, k + 4, 1'b1);  push(0, k + 8, 1'b0); push(0, k + 14, 1'b1);
    push(0, k + 23, 1'b0); push(0, k + 32, 1'b1);
    mon_lo[0] = k + 1; mon_hi[0] = k + 32;
    step(3);
    div_in[15:0] = 16'd6;
    div_we = 2'b01;
    step(1);
    div_we = '0;
    check("t3_pend_after_coincident_wrap", int'(div_pend[0]), 1);
    step(4);
    check("t3_pend_applied_next_wrap", int'(div_pend[0]), 0);
    div_in[15:0] = 16'd7;
    div_we = 2'b01;
    step(1);
    div_in[15:0] = 16'd9;
    step(1);
    div_we = '0;
    check("t3_pend_b2b", int'(div_pend[0]), 1);
    step(4);
    check("t3_pend_b2b_applied", int'(div_pend[0]), 0);
    wait_until(k + 34);
    check("t3_q0_drained", q0.size(), 0);
    en = '0;
    close_windows();
    step(2);

    // D=3 and D=5 at different phases; sync realigns, cnt=0 from the edge after the pulse
    div_in = {16'd5, 16'd3};
    div_we = 2'b11;
    step(1);
    div_we = '0;
    step(1);
    en = 2'b01;
    step(1);
    en = 2'b11;
    step(6);
    k    = cyc;
    sync = 1'b1;
    push(0, k + 4, 1'b1); push(0, k + 7, 1'b0);
    push(1, k + 6, 1'b1); push(1, k + 11, 1'b0);
    mon_lo[0] = k + 1; mon_hi[0] = k + 7;
    mon_lo[1] = k + 1; mon_hi[1] = k + 11;
    step(1);
    sync = 1'b0;
    check("t4_sync_clk_out", int'(clk_out), 0);
    check("t4_sync_tick", int'(tick), 0);
    wait_until(k + 13);
    check("t4_q0_drained", q0.size(), 0);
    check("t4_q1_drained", q1.size(), 0);
    close_windows();

    // Divisor 0 applied by sync: toggle every cycle, tick held high
    k = cyc;
    div_in[15:0] = 16'd0;
    div_we = 2'b01;
    push_run(0, k + 3, 1, 8);
    mon_lo[0] = k + 2; mon_hi[0] = k + 10;
    step(1);
    div_we = '0;
    sync   = 1'b1;
    check("t5_pend_before_sync", int'(div_pend[0]), 1);
    step(1);
    sync = 1'b0;
    check("t5_pend_applied_by_sync", int'(div_pend[0]), 0);
    check("t5_clk_out_after_sync", int'(clk_out[0]), 0);
    wait_until(k + 12);
    check("t5_q0_drained", q0.size(), 0);
    check("t5_tick_held", int'(tick[0]), 1);
    close_windows();

    // Async reset mid-period clears outputs at once; restart takes DEFAULT_DIV cycles
    div_in[31:16] = 16'd7;
    div_we = 2'b10;
    step(1);
    div_we = '0;
    check("t6_pre_pend1", int'(div_pend[1]), 1);
    check("t6_pre_tick0", int'(tick[0]), 1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_clk_out", int'(clk_out), 0);
    check("t6_rst_tick", int'(tick), 0);
    check("t6_rst_pend", int'(div_pend), 0);
    step(2);
    rst = 1'b1;
    k   = cyc;
    push(0, k + DEFAULT_DIV, 1'b1); push(0, k + 2 * DEFAULT_DIV, 1'b0);
    push(1, k + DEFAULT_DIV, 1'b1); push(1, k + 2 * DEFAULT_DIV, 1'b0);
    mon_lo[0] = k + 1; mon_hi[0] = k + 2 * DEFAULT_DIV;
    mon_lo[1] = k + 1; mon_hi[1] = k + 2 * DEFAULT_DIV;
    wait_until(k + 2 * DEFAULT_DIV + 2);
    check("t6_q0_drained", q0.size(), 0);
    check("t6_q1_drained", q1.size(), 0);
    close_windows();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
